// File: rtl/ret_stack_ctrl_pkg.sv
// Shared definitions for the return-address stack: default sizes, control-unit
// opcodes and the per-cycle stack operation decode.
package ret_stack_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DEPTH_DEF  = 8;

  localparam logic [5:0] OP_CALL = 6'b101000;
  localparam logic [5:0] OP_RET  = 6'b111000;

  typedef enum logic [2:0] {
    STK_IDLE,
    STK_PUSH,
    STK_PUSH_FULL,
    STK_PUSH_UNF,
    STK_POP,
    STK_UNDERFLOW,
    STK_REPLACE
  } stk_op_e;

  // Collapse the call/ret strobes and occupancy into one operation per cycle
  function automatic stk_op_e decode_op(input logic call, input logic ret,
                                        input logic empty, input logic full);
    stk_op_e op;
    op = STK_IDLE;
    if (call && ret)
      op = empty ? STK_PUSH_UNF : STK_REPLACE;
    else if (call)
      op = full ? STK_PUSH_FULL : STK_PUSH;
    else if (ret)
      op = empty ? STK_UNDERFLOW : STK_POP;
    return op;
  endfunction

endpackage

// File: rtl/ret_stack_mem.sv
// Return-stack entry storage: DEPTH x ADDR_W, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module ret_stack_mem #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     i_clock,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [ADDR_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [ADDR_W-1:0]        o_rdata
);

  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ret_stack_ctrl.sv
// Hardware return-address stack with overflow/underflow reporting.
// Define RET_STACK_WRAP_EN to let a push while full overwrite the oldest entry.
module ret_stack_ctrl
  import ret_stack_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_call,
  input  logic                       i_ret,
  input  logic [ADDR_W-1:0]          i_ret_in,
  input  logic                       i_clr_err,
  output logic [ADDR_W-1:0]          o_ret_addr,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int unsigned SP_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [SP_W-1:0]   r_sp;
  logic [SP_W-1:0]   w_sp_nxt;
  logic [SP_W-1:0]   w_top_idx;
  logic [SP_W-1:0]   w_waddr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;
  logic              w_ovf_evt;
  logic              w_unf_evt;
  logic              w_we;
  logic              w_empty;
  logic              w_full;
  logic [ADDR_W-1:0] w_rdata;
  stk_op_e           w_op;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_top_idx = r_sp - SP_W'(1);
  assign w_op      = decode_op(i_call, i_ret, w_empty, w_full);

  // Next pointer/count/flag values and the storage write for this cycle
  always_comb begin
    w_sp_nxt    = r_sp;
    w_count_nxt = r_count;
    w_we        = 1'b0;
    w_waddr     = r_sp;
    w_ovf_evt   = 1'b0;
    w_unf_evt   = 1'b0;
    case (w_op)
      STK_PUSH: begin
        w_we        = 1'b1;
        w_sp_nxt    = r_sp + SP_W'(1);
        w_count_nxt = r_count + CNT_W'(1);
      end
      STK_PUSH_UNF: begin
        w_we        = 1'b1;
        w_sp_nxt    = r_sp + SP_W'(1);
        w_count_nxt = r_count + CNT_W'(1);
        w_unf_evt   = 1'b1;
      end
      STK_PUSH_FULL: begin
        w_ovf_evt = 1'b1;
`ifdef RET_STACK_WRAP_EN
        // sp == oldest slot when full, so this overwrites the oldest entry
        w_we      = 1'b1;
        w_sp_nxt  = r_sp + SP_W'(1);
`endif
      end
      STK_POP: begin
        w_sp_nxt    = w_top_idx;
        w_count_nxt = r_count - CNT_W'(1);
      end
      STK_UNDERFLOW: begin
        w_unf_evt = 1'b1;
      end
      STK_REPLACE: begin
        w_we    = 1'b1;
        w_waddr = w_top_idx;
      end
      default: begin
      end
    endcase
    // A same-cycle error event takes priority over clr_err
    w_ovf_nxt = (r_overflow  & ~i_clr_err) | w_ovf_evt;
    w_unf_nxt = (r_underflow & ~i_clr_err) | w_unf_evt;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp        <= w_sp_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= w_ovf_nxt;
      r_underflow <= w_unf_nxt;
    end
  end

  ret_stack_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clock (i_clock),
    .i_we    (w_we & ~i_reset),
    .i_waddr (w_waddr),
    .i_wdata (i_ret_in),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  assign o_ret_addr  = w_empty ? '0 : w_rdata;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_ret_stack_ctrl.sv
// Self-checking bench for ret_stack_ctrl: directed scenarios plus randomized
// call/ret traffic checked against a queue-based reference model.
module tb_ret_stack_ctrl;
  import ret_stack_ctrl_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DP = DEPTH_DEF;
  localparam int unsigned CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_call;
  logic          i_ret;
  logic [AW-1:0] i_ret_in;
  logic          i_clr_err;
  logic [AW-1:0] o_ret_addr;
  logic          o_empty;
  logic          o_full;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          o_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] m_q[$];
  logic          m_ovf;
  logic          m_unf;

  always #5 clk = ~clk;

  ret_stack_ctrl #(
    .ADDR_W (AW),
    .DEPTH  (DP)
  ) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_call      (i_call),
    .i_ret       (i_ret),
    .i_ret_in    (i_ret_in),
    .i_clr_err   (i_clr_err),
    .o_ret_addr  (o_ret_addr),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // LIFO model: back of the queue is the top of stack, front is the oldest entry
  task automatic model_step(input logic c, input logic r, input logic [AW-1:0] a,
                            input logic clr);
    logic oe;
    logic ue;
    oe = 1'b0;
    ue = 1'b0;
    if (c && !r) begin
      if (m_q.size() < DP) m_q.push_back(a);
      else begin
        oe = 1'b1;
`ifdef RET_STACK_WRAP_EN
        m_q.delete(0);
        m_q.push_back(a);
`endif
      end
    end else if (r && !c) begin
      if (m_q.size() > 0) m_q.delete(m_q.size() - 1);
      else ue = 1'b1;
    end else if (c && r) begin
      if (m_q.size() > 0) m_q[m_q.size() - 1] = a;
      else begin
        m_q.push_back(a);
        ue = 1'b1;
      end
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    m_ovf = m_ovf | oe;
    m_unf = m_unf | ue;
  endtask

  task automatic check_state(input string tag);
    logic [AW-1:0] top;
    int            n;
    n   = m_q.size();
    top = (n > 0) ? m_q[n - 1] : '0;
    check({tag, ".ret_addr"},  32'(o_ret_addr),  32'(top));
    check({tag, ".count"},     32'(o_count),     32'(n));
    check({tag, ".empty"},     32'(o_empty),     32'(n == 0));
    check({tag, ".full"},      32'(o_full),      32'(n == DP));
    check({tag, ".overflow"},  32'(o_overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(o_underflow), 32'(m_unf));
  endtask

  task automatic step(input string tag, input logic c, input logic r,
                      input logic [AW-1:0] a, input logic clr);
    i_call    = c;
    i_ret     = r;
    i_ret_in  = a;
    i_clr_err = clr;
    @(posedge clk);
    model_step(c, r, a, clr);
    #1;
    i_call    = 1'b0;
    i_ret     = 1'b0;
    i_clr_err = 1'b0;
    check_state(tag);
  endtask

  initial begin
    i_reset   = 1'b1;
    i_call    = 1'b0;
    i_ret     = 1'b0;
    i_ret_in  = '0;
    i_clr_err = 1'b0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    check_state("reset");

    // 1: async reset mid-stream, then held across edges with a call pending
    step("t1_unf", 1'b0, 1'b1, '0, 1'b0);
    for (int k = 0; k < 3; k++) step("t1_push", 1'b1, 1'b0, AW'(16 * (k + 1)), 1'b0);
    #2;
    i_reset  = 1'b1;
    i_call   = 1'b1;
    i_ret_in = AW'(12'h3AA);
    #1;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_state("t1_async");
    repeat (2) @(posedge clk);
    #1;
    check_state("t1_held");
    i_reset = 1'b0;
    i_call  = 1'b0;

    // 2: three pushes then three pops, ret_addr checked in each pop cycle
    for (int k = 0; k < 3; k++) step("t2_push", 1'b1, 1'b0, AW'(16 * (k + 1)), 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t2_pop_addr", 32'(o_ret_addr), 32'(48 - 16 * k));
      step("t2_pop", 1'b0, 1'b1, '0, 1'b0);
    end
    check("t2_empty", 32'(o_empty), 32'd1);

    // 3: pop on empty, then clear
    step("t3_unf", 1'b0, 1'b1, '0, 1'b0);
    check("t3_unf_flag", 32'(o_underflow), 32'd1);
    check("t3_addr", 32'(o_ret_addr), 32'd0);
    step("t3_clr", 1'b0, 1'b0, '0, 1'b1);
    check("t3_unf_clr", 32'(o_underflow), 32'd0);

    // 4: DEPTH+1 pushes, then drain
    for (int k = 0; k <= DP; k++) step("t4_push", 1'b1, 1'b0, AW'(256 + k), 1'b0);
    check("t4_full", 32'(o_full), 32'd1);
    check("t4_ovf", 32'(o_overflow), 32'd1);
    for (int k = 0; k < DP; k++) begin
`ifdef RET_STACK_WRAP_EN
      check("t4_pop_addr", 32'(o_ret_addr), 32'(256 + DP - k));
`else
      check("t4_pop_addr", 32'(o_ret_addr), 32'(256 + DP - 1 - k));
`endif
      step("t4_pop", 1'b0, 1'b1, '0, 1'b0);
    end
    check("t4_empty", 32'(o_empty), 32'd1);
    step("t4_clr", 1'b0, 1'b0, '0, 1'b1);

    // 5: call && ret replaces the top entry
    step("t5_push", 1'b1, 1'b0, AW'(12'h040), 1'b0);
    step("t5_push", 1'b1, 1'b0, AW'(12'h050), 1'b0);
    step("t5_repl", 1'b1, 1'b1, AW'(12'h055), 1'b0);
    check("t5_count", 32'(o_count), 32'd2);
    check("t5_addr", 32'(o_ret_addr), 32'h055);
    step("t5_pop", 1'b0, 1'b1, '0, 1'b0);
    check("t5_pop_addr", 32'(o_ret_addr), 32'h040);
    step("t5_pop", 1'b0, 1'b1, '0, 1'b0);

    // 6: clr_err with an underflow in the same cycle keeps the flag set
    step("t6", 1'b0, 1'b1, '0, 1'b1);
    check("t6_unf", 32'(o_underflow), 32'd1);
    step("t6_clr", 1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic, alternating call-heavy and ret-heavy phases
    for (int i = 0; i < 600; i++) begin
      int            p;
      int            call_pct;
      logic [5:0]    op;
      logic          both;
      logic [AW-1:0] a;
      p        = int'($urandom_range(0, 99));
      call_pct = ((i / 40) % 2 == 0) ? 60 : 25;
      both     = (p >= 90);
      if (p < call_pct) op = OP_CALL;
      else if (p < 85)  op = OP_RET;
      else              op = 6'h00;
      a = AW'($urandom);
      step("rand", both || (op == OP_CALL), both || (op == OP_RET), a,
           ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
